// File: rtl/seg7_pkg.sv
// Shared glyph table and types for the seven-segment scan decoder.
// Active-low glyphs, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef logic [3:0] hex_t;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    HOLD
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational reverse lookup of an active-low segment pattern.
// Anything outside the 16-entry glyph table is flagged as not legal.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output hex_t       value,
  output logic       legal
);

  always_comb begin
    value = '0;
    legal = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_GLYPH[i]) begin
        value = hex_t'(i);
        legal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Rebuilds per-digit hex values from a scanned seven-segment bus.
// Define SEG7_SCAN_DP_EN to also track the decimal point (dp/dp_out).
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
`ifdef SEG7_SCAN_DP_EN
  input  logic                    dp,
  output logic [NUM_DIGITS-1:0]   dp_out,
`endif
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    bad_pattern,
  output logic                    frame_done
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYCLES);
  localparam logic [NUM_DIGITS-1:0] ALL = '1;

  logic [6:0]            seg_s1, seg_q;
  logic [NUM_DIGITS-1:0] an_s1, an_q;
`ifdef SEG7_SCAN_DP_EN
  logic                  dp_s1, dp_q;
`endif

  scan_state_t           state, state_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic [NUM_DIGITS-1:0] seen, seen_d;
  logic [NUM_DIGITS-1:0] sel;
  logic                  sel_ok;
  logic                  chg;
  logic                  cap;
  logic                  seen_full;
  hex_t                  value;
  logic                  legal;

  seg7_glyph_decode u_dec (
    .seg   (seg_q),
    .value (value),
    .legal (legal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_s1 <= SEG_BLANK;
      seg_q  <= SEG_BLANK;
      an_s1  <= '1;
      an_q   <= '1;
`ifdef SEG7_SCAN_DP_EN
      dp_s1  <= 1'b1;
      dp_q   <= 1'b1;
`endif
    end else begin
      seg_s1 <= seg;
      seg_q  <= seg_s1;
      an_s1  <= an;
      an_q   <= an_s1;
`ifdef SEG7_SCAN_DP_EN
      dp_s1  <= dp;
      dp_q   <= dp_s1;
`endif
    end
  end

  // chg looks one stage ahead: it is set the cycle before seg_q/an_q move,
  // so the counter restarts on the same edge the new value lands.
  always_comb begin
    chg = (seg_s1 != seg_q) || (an_s1 != an_q);
`ifdef SEG7_SCAN_DP_EN
    chg = chg || (dp_s1 != dp_q);
`endif
  end

  assign sel       = ~an_q;
  assign sel_ok    = $onehot(sel);
  assign seen_full = (seen == ALL);

  always_comb begin
    state_d = state;
    cap     = 1'b0;
    if (chg)
      cnt_d = '0;
    else if (cnt == CNT_MAX)
      cnt_d = cnt;
    else
      cnt_d = cnt + 1'b1;
    unique case (state)
      IDLE: begin
        if (!(&an_q))
          state_d = SETTLE;
      end
      SETTLE: begin
        if (&an_q)
          state_d = IDLE;
        else if (!chg && (int'(cnt) + 1 >= SETTLE_CYCLES))
          state_d = CAPTURE;
      end
      CAPTURE: begin
        cap = 1'b1;
        if (chg)
          state_d = (&an_s1) ? IDLE : SETTLE;
        else
          state_d = HOLD;
      end
      HOLD: begin
        if (chg)
          state_d = (&an_s1) ? IDLE : SETTLE;
      end
    endcase
  end

  always_comb begin
    seen_d = seen_full ? '0 : seen;
    if (cap && sel_ok)
      seen_d = seen_d | sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      seen  <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      seen  <= seen_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digits      <= '0;
      digit_valid <= '0;
      bad_pattern <= 1'b0;
      frame_done  <= 1'b0;
`ifdef SEG7_SCAN_DP_EN
      dp_out      <= '0;
`endif
    end else begin
      frame_done <= seen_full;
      if (cap) begin
        if (!sel_ok) begin
          bad_pattern <= 1'b1;
        end else if (!legal) begin
          bad_pattern <= 1'b1;
          digit_valid <= digit_valid & an_q;
        end else begin
          digit_valid <= digit_valid | sel;
          for (int i = 0; i < NUM_DIGITS; i++)
            if (sel[i])
              digits[4*i +: 4] <= value;
`ifdef SEG7_SCAN_DP_EN
          dp_out <= (dp_out & an_q) | (sel & {NUM_DIGITS{~dp_q}});
`endif
        end
      end
    end
  end

endmodule
